// File: rtl/voice_allocator.sv
// Voice allocator: scans the voice table for a retrigger/free/oldest voice and
// issues note-on/off register strobes. Build option: VOICE_STEAL_EN (steal oldest when full).

module voice_slot #(
  parameter int AGE_W = 8
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             commit,
  input  logic             hit,
  input  logic             set_on,
  input  logic [6:0]       new_key,
  output logic             active,
  output logic [6:0]       key,
  output logic [AGE_W-1:0] age
);
  always_ff @(posedge sysclk) begin
    if (reset) begin
      active <= 1'b0;
      key    <= '0;
      age    <= '0;
    end else if (commit) begin
      if (hit) begin
        active <= set_on;
        if (set_on) begin
          key <= new_key;
          age <= '0;
        end
      end else if (set_on && active && age != {AGE_W{1'b1}}) begin
        age <= age + 1'b1;
      end
    end
  end
endmodule

module voice_allocator #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3,
  parameter int AGE_W   = 8
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_on,
  input  logic [6:0]         ev_key,
  input  logic [6:0]         ev_vel,
  output logic               reg_note_on,
  output logic               reg_note_off,
  output logic [V_WIDTH-1:0] reg_cur_key_adr,
  output logic [7:0]         reg_cur_vel_on,
  output logic [6:0]         reg_cur_key,
  output logic [VOICES-1:0]  voices_active,
  output logic               ev_dropped
);
  typedef enum logic [1:0] {IDLE, SCAN, SETUP, STROBE} state_t;
  state_t state, state_n;

  logic                          op_on;
  logic [6:0]                    op_key, op_vel;
  logic [V_WIDTH-1:0]            scan_idx;
  logic                          last;
  logic                          m_found, m_found_n, f_found, f_found_n;
  logic [V_WIDTH-1:0]            m_idx, m_idx_n, f_idx, f_idx_n, tgt;
  logic                          drop_n, drop_q, commit;
  logic [VOICES-1:0][6:0]        slot_key;
  logic [VOICES-1:0][AGE_W-1:0]  slot_age;

  assign last   = (scan_idx == V_WIDTH'(VOICES-1));
  assign commit = (state == SCAN) && last && !drop_n;

  for (genvar i = 0; i < VOICES; i++) begin : g_slot
    voice_slot #(.AGE_W(AGE_W)) u_slot (
      .sysclk  (sysclk),
      .reset   (reset),
      .commit  (commit),
      .hit     (tgt == V_WIDTH'(i)),
      .set_on  (op_on),
      .new_key (op_key),
      .active  (voices_active[i]),
      .key     (slot_key[i]),
      .age     (slot_age[i])
    );
  end

  // Trackers including the voice under the scan pointer this cycle.
  always_comb begin
    m_found_n = m_found;
    m_idx_n   = m_idx;
    f_found_n = f_found;
    f_idx_n   = f_idx;
    if (!m_found && voices_active[scan_idx] && slot_key[scan_idx] == op_key) begin
      m_found_n = 1'b1;
      m_idx_n   = scan_idx;
    end
    if (!f_found && !voices_active[scan_idx]) begin
      f_found_n = 1'b1;
      f_idx_n   = scan_idx;
    end
  end

`ifdef VOICE_STEAL_EN
  logic [V_WIDTH-1:0] o_idx, o_idx_n;
  logic [AGE_W-1:0]   o_age, o_age_n;

  // Strict compare keeps ties on the lowest index.
  always_comb begin
    o_idx_n = o_idx;
    o_age_n = o_age;
    if (scan_idx == '0 || slot_age[scan_idx] > o_age) begin
      o_idx_n = scan_idx;
      o_age_n = slot_age[scan_idx];
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      o_idx <= '0;
      o_age <= '0;
    end else if (state == SCAN) begin
      o_idx <= o_idx_n;
      o_age <= o_age_n;
    end
  end
`else
  logic unused_age;
  assign unused_age = ^slot_age;
`endif

  always_comb begin
    tgt    = m_idx_n;
    drop_n = 1'b0;
    if (m_found_n) begin
      tgt = m_idx_n;
    end else if (op_on && f_found_n) begin
      tgt = f_idx_n;
    end else if (op_on) begin
`ifdef VOICE_STEAL_EN
      tgt = o_idx_n;
`else
      drop_n = 1'b1;
`endif
    end else begin
      drop_n = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ev_valid) state_n = SCAN;
      SCAN:    if (last) state_n = SETUP;
      SETUP:   state_n = drop_q ? IDLE : STROBE;
      STROBE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The decision is committed on the edge into SETUP so the table and the
  // register outputs are already valid for the whole SETUP cycle.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state           <= IDLE;
      op_on           <= 1'b0;
      op_key          <= '0;
      op_vel          <= '0;
      scan_idx        <= '0;
      m_found         <= 1'b0;
      m_idx           <= '0;
      f_found         <= 1'b0;
      f_idx           <= '0;
      drop_q          <= 1'b0;
      reg_cur_key_adr <= '0;
      reg_cur_key     <= '0;
      reg_cur_vel_on  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (ev_valid) begin
          op_on    <= ev_on && (ev_vel != 7'd0);
          op_key   <= ev_key;
          op_vel   <= ev_vel;
          scan_idx <= '0;
          m_found  <= 1'b0;
          f_found  <= 1'b0;
        end
        SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          m_found  <= m_found_n;
          m_idx    <= m_idx_n;
          f_found  <= f_found_n;
          f_idx    <= f_idx_n;
          if (last) begin
            drop_q <= drop_n;
            if (!drop_n) begin
              reg_cur_key_adr <= tgt;
              reg_cur_key     <= op_key;
              if (op_on) reg_cur_vel_on <= {op_vel, op_vel[6]};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ev_ready     = (state == IDLE);
  assign reg_note_on  = (state == STROBE) && op_on;
  assign reg_note_off = (state == STROBE) && !op_on;
  assign ev_dropped   = (state == SETUP) && drop_q;
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Writer side of the per-voice note-on register interface consumed by the synth engine's velocity and envelope stores.
- Accepts decoded MIDI note-on/note-off events, then picks a voice: retrigger, first free, or oldest steal.
- Emits reg_note_on / reg_note_off strobes with stable key address and velocity.
- Sits between the MIDI decoder and synth_engine; keeps the voice table (active, key, age).

Parameters:
- VOICES, 8, number of voices (power of 2).
- V_WIDTH, 3, voice index width, log2(VOICES).
- AGE_W, 8, per-voice age counter width (saturating).

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  high only in IDLE; an event is accepted when ev_valid & ev_ready.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_key  in  7  MIDI key number.
- ev_vel  in  7  MIDI velocity.
- reg_note_on  out  1  one-cycle write strobe for the velocity store.
- reg_note_off  out  1  one-cycle release strobe.
- reg_cur_key_adr  out  V_WIDTH  target voice index.
- reg_cur_vel_on  out  8  expanded velocity.
- reg_cur_key  out  7  key assigned to target voice.
- voices_active  out  VOICES  per-voice active mask.
- ev_dropped  out  1  one-cycle pulse when an event produces no strobe.

Behaviour:
- Reset: state IDLE; table cleared (active=0, key=0, age=0). All outputs 0 except ev_ready=1. Applies mid-scan too: any pending strobe is cancelled.
- FSM: IDLE -> SCAN -> SETUP -> STROBE -> IDLE.
- IDLE: on accept, latch ev_on/ev_key/ev_vel. Note-on with ev_vel=0 becomes note-off. ev_ready goes low the next cycle.
- SCAN: exactly VOICES cycles, one voice index per cycle, from 0 upward. Tracks:
  - match: first active voice with key == latched key;
  - free: first inactive voice;
  - oldest: voice with max age; ties go to the lowest index.
- SETUP (1 cycle), target selection:
  - note-on: match, else free, else oldest.
  - note-off: match, else drop (ev_dropped pulse, no strobe, go straight to IDLE).
- SETUP outputs: registers reg_cur_key_adr, reg_cur_key, and (on note-on) reg_cur_vel_on = {vel, vel[6]}, so 127->255, 64->129, 1->2.
- SETUP table update (note-on):
  - target: active=1, key=latched key, age=0;
  - every other active voice: age+1, saturating at 2^AGE_W-1.
- SETUP table update (note-off): target active=0, age unchanged.
- STROBE (1 cycle): reg_note_on or reg_note_off = 1.
- Data stability: adr/key/vel change only in SETUP. They are stable one cycle before, during, and after the strobe, and held until the next SETUP, because downstream uses the strobe as an edge.
- Latency: accept at cycle 0 -> strobe at cycle VOICES+2 -> ev_ready high at cycle VOICES+3. Throughput is one event per VOICES+3 cycles.
- Strobes are never both high. ev_valid while ev_ready=0 is ignored; the upstream source holds it.
- voices_active reflects the table; it updates in the SETUP cycle.
- Note-off does not modify reg_cur_vel_on.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: when all voices are active and there is no match, a note-on steals the oldest voice, as above.
- Undefined: that note-on is dropped instead. ev_dropped pulses in SETUP, there is no strobe, the table is unchanged, and the FSM returns to IDLE. Retrigger and free allocation are unaffected.

Test Plan (VOICES=8):
- Reset then note-on key 60, vel 127 -> reg_note_on at cycle 10 after accept; adr=0, vel=8'hFF, key=60, voices_active=8'h01.
- Note-on keys 60, 62, 64 (vel 64), then note-on 62 vel 100 -> retrigger: adr=1, vel=8'hC9; voices_active=8'h07.
- Note-on key 60 vel 0 after key 60 active on voice 0 -> reg_note_off, adr=0, voices_active bit 0 cleared. Then note-off key 99 -> ev_dropped, no strobe.
- Fill all 8 voices (keys 40..47), then note-on key 50:
  - with VOICE_STEAL_EN: adr=0 (oldest), key=50;
  - without it: ev_dropped and voices_active=8'hFF unchanged.
- Assert reset during SCAN -> no strobe follows; next cycle voices_active=0 and ev_ready=1.
- Hold ev_valid high continuously with alternating on/off events -> one accept per 11 cycles. adr/vel are stable from the cycle before each strobe through the cycle after it.
